tex_texel_gather: RTL and testbench

Texel fetch front-end that feeds the texture sampler. It accepts one texture request per warp: per active lane, four texel addresses plus blend fractions. It issues the 4 × (active lanes) 32-bit memory reads one at a time, collects out-of-order tagged responses into a texel buffer, and presents the complete quad set to the sampler with a valid/ready handshake. Format, blends, thread mask and request info pass through unchanged.

---
 rtl/tex_texel_gather_if.sv | 66 ++++++
 rtl/tex_texel_gather.sv | 166 ++++++++++++++++
 tb/tb_tex_texel_gather.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tex_texel_gather_if.sv
// Bundle of request, memory and sampler-side signals for the texel gather block.
// No logic here; widths follow the gather block parameters.
// "slave" is the gather block's view, "master" is the surrounding system's view.
`ifndef TEX_FORMAT_BITS
`define TEX_FORMAT_BITS 3
`endif
`ifndef TEX_BLEND_FRAC
`define TEX_BLEND_FRAC 8
`endif

interface tex_texel_gather_if #(
    parameter int NUM_REQS  = 4,
    parameter int REQ_INFOW = 1
);
    localparam int TAG_W = $clog2(NUM_REQS) + 2;

    // Request from the warp front-end.
    logic                                           req_valid;
    logic [NUM_REQS-1:0]                            req_tmask;
    logic [`TEX_FORMAT_BITS-1:0]                    req_format;
    logic [NUM_REQS-1:0][3:0][31:0]                 req_addr;
    logic [NUM_REQS-1:0][1:0][`TEX_BLEND_FRAC-1:0]  req_blends;
    logic [REQ_INFOW-1:0]                           req_info;
    logic                                           req_ready;

    // Memory read port.
    logic                                           mem_req_valid;
    logic [31:0]                                    mem_req_addr;
    logic [TAG_W-1:0]                               mem_req_tag;
    logic                                           mem_req_ready;
    logic                                           mem_rsp_valid;
    logic [31:0]                                    mem_rsp_data;
    logic [TAG_W-1:0]                               mem_rsp_tag;
    logic                                           mem_rsp_ready;

    // Sampler side.
    logic                                           out_valid;
    logic [NUM_REQS-1:0]                            out_tmask;
    logic [`TEX_FORMAT_BITS-1:0]                    out_format;
    logic [NUM_REQS-1:0][1:0][`TEX_BLEND_FRAC-1:0]  out_blends;
    logic [REQ_INFOW-1:0]                           out_info;
    logic [NUM_REQS-1:0][3:0][31:0]                 out_data;
    logic                                           out_ready;

    modport slave (
        input  req_valid, req_tmask, req_format, req_addr, req_blends, req_info,
        output req_ready,
        output mem_req_valid, mem_req_addr, mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready,
        output out_valid, out_tmask, out_format, out_blends, out_info, out_data,
        input  out_ready
    );

    modport master (
        output req_valid, req_tmask, req_format, req_addr, req_blends, req_info,
        input  req_ready,
        input  mem_req_valid, mem_req_addr, mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready,
        input  out_valid, out_tmask, out_format, out_blends, out_info, out_data,
        output out_ready
    );
endinterface

// File: rtl/tex_texel_gather.sv
// Texel gather: issues 4 reads per active lane, collects tagged responses, hands the quad set to the sampler.
// Latency: first read the cycle after accept; out_valid the cycle after the last response is captured.
// Backpressure: one request in flight; reads stall on mem_req_ready; responses held off outside ISSUE/WAIT; SEND holds until out_ready.
module tex_texel_gather #(
    parameter int NUM_REQS  = 4,
    parameter int REQ_INFOW = 1
) (
    input  logic              clk,
    input  logic              reset,
    tex_texel_gather_if.slave bus
);
    localparam int LANE_W = $clog2(NUM_REQS);
    localparam int TAG_W  = LANE_W + 2;
    localparam int CNT_W  = $clog2(4 * NUM_REQS + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SEND} state_t;

    state_t state, state_nxt;

    logic [NUM_REQS-1:0]                           tmask_q;
    logic [`TEX_FORMAT_BITS-1:0]                   format_q;
    logic [NUM_REQS-1:0][3:0][31:0]                addr_q;
    logic [NUM_REQS-1:0][3:0][31:0]                data_q;
    logic [NUM_REQS-1:0][1:0][`TEX_BLEND_FRAC-1:0] blends_q;
    logic [REQ_INFOW-1:0]                          info_q;

    logic [LANE_W-1:0] lane_q;
    logic [1:0]        texel_q;
    logic [CNT_W-1:0]  rcv_cnt;
    logic [CNT_W-1:0]  expected;

    logic              accept;
    logic              issue_fire;
    logic              last_issue;
    logic              rsp_fire;
    logic              all_in;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              nxt_found;
    logic [LANE_W-1:0] nxt_lane;
    logic [LANE_W-1:0] acc_lane;
    logic [LANE_W-1:0] rsp_lane;
    logic [1:0]        rsp_texel;

    // Four reads per set mask bit.
    function automatic logic [CNT_W-1:0] quad_count(input logic [NUM_REQS-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, m[i]};
        end
        return c << 2;
    endfunction

    assign accept     = (state == IDLE) && bus.req_valid;
    assign issue_fire = (state == ISSUE) && bus.mem_req_ready;
    assign rsp_fire   = bus.mem_rsp_valid && bus.mem_rsp_ready;
    assign cnt_nxt    = rcv_cnt + {{(CNT_W-1){1'b0}}, rsp_fire};
    // Counts the response landing this cycle, so a late response never costs an extra cycle.
    assign all_in     = (cnt_nxt == expected);
    assign last_issue = (texel_q == 2'd3) && !nxt_found;
    assign rsp_lane   = bus.mem_rsp_tag[TAG_W-1:2];
    assign rsp_texel  = bus.mem_rsp_tag[1:0];

    // Lowest active lane above the current one; inactive lanes are skipped whole.
    always_comb begin
        nxt_found = 1'b0;
        nxt_lane  = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (tmask_q[i] && (i > int'(lane_q))) begin
                nxt_found = 1'b1;
                nxt_lane  = LANE_W'(i);
            end
        end
    end

    // Lowest active lane of the incoming request, the issue starting point.
    always_comb begin
        acc_lane = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (bus.req_tmask[i]) begin
                acc_lane = LANE_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.req_valid) state_nxt = (bus.req_tmask != '0) ? ISSUE : SEND;
            ISSUE: if (issue_fire && last_issue) state_nxt = all_in ? SEND : WAIT;
            WAIT:  if (all_in) state_nxt = SEND;
            SEND:  if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only; req_ready also drops while reset is held.
    always_comb begin
        bus.req_ready     = (state == IDLE) && reset;
        bus.mem_req_valid = (state == ISSUE);
        bus.mem_rsp_ready = (state == ISSUE) || (state == WAIT);
        bus.out_valid     = (state == SEND);
    end

    assign bus.mem_req_addr = addr_q[lane_q][texel_q];
    assign bus.mem_req_tag  = {lane_q, texel_q};
    assign bus.out_tmask    = tmask_q;
    assign bus.out_format   = format_q;
    assign bus.out_blends   = blends_q;
    assign bus.out_info     = info_q;
    assign bus.out_data     = data_q;

    // Request latch, issue pointer walk and response capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmask_q  <= '0;
            format_q <= '0;
            addr_q   <= '0;
            blends_q <= '0;
            info_q   <= '0;
            data_q   <= '0;
            lane_q   <= '0;
            texel_q  <= '0;
            rcv_cnt  <= '0;
            expected <= '0;
        end else begin
            if (accept) begin
                tmask_q  <= bus.req_tmask;
                format_q <= bus.req_format;
                addr_q   <= bus.req_addr;
                blends_q <= bus.req_blends;
                info_q   <= bus.req_info;
                data_q   <= '0;
                lane_q   <= acc_lane;
                texel_q  <= 2'd0;
                rcv_cnt  <= '0;
                expected <= quad_count(bus.req_tmask);
            end
            if (issue_fire && !last_issue) begin
                if (texel_q == 2'd3) begin
                    lane_q  <= nxt_lane;
                    texel_q <= 2'd0;
                end else begin
                    texel_q <= texel_q + 2'd1;
                end
            end
            if (rsp_fire) begin
                // Inactive lanes stay zero even if a stray tag names them.
                if (tmask_q[rsp_lane]) begin
                    data_q[rsp_lane][rsp_texel] <= bus.mem_rsp_data;
                end
                rcv_cnt <= cnt_nxt;
            end
        end
    end
endmodule

// File: tb/tb_tex_texel_gather.sv
`timescale 1ns/1ps
`ifndef TEX_FORMAT_BITS
`define TEX_FORMAT_BITS 3
`endif
`ifndef TEX_BLEND_FRAC
`define TEX_BLEND_FRAC 8
`endif

module tb_tex_texel_gather;
    localparam int NR    = 4;
    localparam int FW    = `TEX_FORMAT_BITS;
    localparam int BW    = `TEX_BLEND_FRAC;
    localparam int M_ONE = 0;   // ready always, in-order responses one cycle after issue
    localparam int M_REV = 1;   // ready toggling, responses reversed with 1-10 cycle gaps
    localparam int M_LIM = 2;   // like M_ONE but stops after rsp_limit responses

    typedef logic [NR-1:0][3:0][31:0]   addr_t;
    typedef logic [NR-1:0][1:0][BW-1:0] blend_t;
    typedef struct { logic [3:0] tag; logic [31:0] dat; int due; } pend_t;
    typedef struct { logic [3:0] tag; logic [31:0] addr; int at; } iss_t;
    typedef struct { logic [3:0] tmask; bit rnd_addr; int mode; int hold; int exp_issues; int exp_out; } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int          mode = M_ONE;
    int          n_exp = 0;
    int          issued_cnt = 0;
    int          rsp_cnt = 0;
    int          rsp_limit = 0;
    int          gap = 0;
    int          last_rsp_cyc = -1;
    int          t0 = 0;
    logic [31:0] salt = '0;
    pend_t       pend_q[$];
    iss_t        iss_q[$];

    logic [3:0]    e_tmask;
    addr_t         e_addr;
    logic [FW-1:0] e_format;
    blend_t        e_blends;
    logic          e_info;

    tex_texel_gather_if #(.NUM_REQS(NR), .REQ_INFOW(1)) bus ();
    tex_texel_gather #(.NUM_REQS(NR), .REQ_INFOW(1)) dut (.clk(clk), .reset(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic addr_t base_addr();
        addr_t a;
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < 4; j++)
                a[i][j] = 32'h1000 + 32'(16 * i + 4 * j);
        return a;
    endfunction

    function automatic addr_t rand_addr();
        addr_t a;
        logic [31:0] w;
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < 4; j++) begin
                w = $urandom;
                w[1:0] = 2'b00;
                a[i][j] = w;
            end
        return a;
    endfunction

    // Gathered texels as the sampler should see them: memory data for active lanes, zero elsewhere.
    function automatic addr_t model_data();
        addr_t d;
        d = '0;
        for (int i = 0; i < NR; i++)
            if (e_tmask[i])
                for (int j = 0; j < 4; j++)
                    d[i][j] = e_addr[i][j] ^ salt;
        return d;
    endfunction

    // Memory model: serves responses, logs issues, checks address/tag stability while stalled.
    initial begin
        bit          have;
        int          idx;
        logic        prev_v;
        logic        prev_r;
        logic [31:0] prev_a;
        logic [3:0]  prev_t;
        prev_v = 1'b0; prev_r = 1'b0; prev_a = '0; prev_t = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.mem_rsp_tag   = '0;
        forever begin
            @(negedge clk);
            have = 1'b0;
            idx  = 0;
            if (rst_n) begin
                if (mode == M_REV) begin
                    if (issued_cnt == n_exp && pend_q.size() > 0) begin
                        if (gap > 0) gap--;
                        else begin have = 1'b1; idx = pend_q.size() - 1; end
                    end
                end else if (pend_q.size() > 0 && pend_q[0].due <= cyc &&
                             (mode != M_LIM || rsp_cnt < rsp_limit)) begin
                    have = 1'b1;
                end
            end
            bus.mem_rsp_valid = have;
            if (have) begin
                bus.mem_rsp_data = pend_q[idx].dat;
                bus.mem_rsp_tag  = pend_q[idx].tag;
                if (bus.mem_rsp_ready) begin
                    pend_q.delete(idx);
                    rsp_cnt++;
                    last_rsp_cyc = cyc;
                    if (mode == M_REV) gap = $urandom_range(0, 9);
                end
            end
            bus.mem_req_ready = (mode == M_REV) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_v && !prev_r) begin
                chk("req_stable_valid", 512'(bus.mem_req_valid), 512'(1));
                chk("req_stable_addr", 512'(bus.mem_req_addr), 512'(prev_a));
                chk("req_stable_tag", 512'(bus.mem_req_tag), 512'(prev_t));
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                iss_q.push_back('{bus.mem_req_tag, bus.mem_req_addr, cyc});
                pend_q.push_back('{bus.mem_req_tag, bus.mem_req_addr ^ salt, cyc + 1});
                issued_cnt++;
            end
            prev_v = bus.mem_req_valid;
            prev_r = bus.mem_req_ready;
            prev_a = bus.mem_req_addr;
            prev_t = bus.mem_req_tag;
        end
    end

    task automatic submit(input logic [3:0] tm, input addr_t ad);
        int n;
        n = 0;
        while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
        chk("req_ready_before_submit", 512'(bus.req_ready), 512'(1));
        iss_q.delete();
        pend_q.delete();
        issued_cnt = 0; rsp_cnt = 0; gap = $urandom_range(0, 9); last_rsp_cyc = -1;
        n_exp    = 4 * $countones(tm);
        e_tmask  = tm;
        e_addr   = ad;
        e_format = FW'($urandom);
        e_blends = {$urandom, $urandom};
        e_info   = 1'($urandom);
        bus.req_tmask  = tm;
        bus.req_addr   = ad;
        bus.req_format = e_format;
        bus.req_blends = e_blends;
        bus.req_info   = e_info;
        bus.req_valid  = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_tmask  = 4'($urandom);
        bus.req_addr   = rand_addr();
        bus.req_format = FW'($urandom);
        bus.req_blends = {$urandom, $urandom};
        bus.req_info   = 1'($urandom);
    endtask

    task automatic finish_req(input int hold, input int exp_issues, input int exp_out);
        int    n;
        int    oc;
        int    k;
        addr_t snap;
        n = 0;
        while (!bus.out_valid && n < 2000) begin @(negedge clk); n++; end
        chk("out_valid_seen", 512'(bus.out_valid), 512'(1));
        oc = cyc - t0;
        if (n_exp == 0) chk("out_cycle_empty", 512'(oc), 512'(1));
        else chk("out_after_last_rsp", 512'(oc), 512'(last_rsp_cyc - t0 + 1));
        if (exp_out >= 0) chk("out_cycle", 512'(oc), 512'(exp_out));
        chk("rsp_count", 512'(rsp_cnt), 512'(n_exp));
        chk("issue_count", 512'(iss_q.size()), 512'(exp_issues));
        k = 0;
        for (int i = 0; i < NR; i++)
            if (e_tmask[i])
                for (int j = 0; j < 4; j++) begin
                    if (k < iss_q.size()) begin
                        chk("issue_tag", 512'(iss_q[k].tag), 512'(4 * i + j));
                        chk("issue_addr", 512'(iss_q[k].addr), 512'(e_addr[i][j]));
                    end
                    k++;
                end
        if (mode == M_ONE && iss_q.size() > 0)
            chk("first_issue_cycle", 512'(iss_q[0].at - t0), 512'(1));
        chk("out_data", 512'(bus.out_data), 512'(model_data()));
        chk("out_tmask", 512'(bus.out_tmask), 512'(e_tmask));
        chk("out_format", 512'(bus.out_format), 512'(e_format));
        chk("out_blends", 512'(bus.out_blends), 512'(e_blends));
        chk("out_info", 512'(bus.out_info), 512'(e_info));
        snap = bus.out_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", 512'(bus.out_valid), 512'(1));
            chk("hold_out_data", 512'(bus.out_data), 512'(snap));
            chk("hold_out_tmask", 512'(bus.out_tmask), 512'(e_tmask));
            chk("hold_req_ready", 512'(bus.req_ready), 512'(0));
            chk("hold_rsp_ready", 512'(bus.mem_rsp_ready), 512'(0));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("idle_after_out", 512'(bus.req_ready), 512'(1));
        chk("out_valid_drop", 512'(bus.out_valid), 512'(0));
    endtask

    initial begin
        vec_t       vt[6];
        logic [3:0] tm;
        int         n;

        bus.req_valid  = 1'b0;
        bus.req_tmask  = '0;
        bus.req_format = '0;
        bus.req_addr   = '0;
        bus.req_blends = '0;
        bus.req_info   = '0;
        bus.out_ready  = 1'b0;

        //        tmask    rnd   mode   hold issues out_cycle
        vt[0] = '{4'b1111, 1'b0, M_ONE, 0,   16,    18};
        vt[1] = '{4'b0100, 1'b0, M_ONE, 0,   4,     6};
        vt[2] = '{4'b0000, 1'b0, M_ONE, 0,   0,     1};
        vt[3] = '{4'b1111, 1'b0, M_REV, 0,   16,    -1};
        vt[4] = '{4'b1010, 1'b0, M_ONE, 5,   8,     10};
        vt[5] = '{4'b1001, 1'b1, M_REV, 2,   8,     -1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 512'(bus.req_ready), 512'(0));
        chk("rst_mem_req_valid", 512'(bus.mem_req_valid), 512'(0));
        chk("rst_mem_rsp_ready", 512'(bus.mem_rsp_ready), 512'(0));
        chk("rst_out_valid", 512'(bus.out_valid), 512'(0));
        chk("rst_out_data", 512'(bus.out_data), 512'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_rst", 512'(bus.req_ready), 512'(1));

        for (int v = 0; v < 6; v++) begin
            salt = (v == 0) ? 32'h0 : $urandom;
            mode = vt[v].mode;
            submit(vt[v].tmask, vt[v].rnd_addr ? rand_addr() : base_addr());
            finish_req(vt[v].hold, vt[v].exp_issues, vt[v].exp_out);
        end

        for (int r = 0; r < 8; r++) begin
            tm   = 4'($urandom);
            salt = $urandom;
            mode = ($urandom_range(0, 1) == 0) ? M_ONE : M_REV;
            submit(tm, rand_addr());
            finish_req($urandom_range(0, 3), 4 * $countones(tm), -1);
        end

        // Abort in WAIT after 7 of 16 responses.
        mode = M_LIM;
        rsp_limit = 7;
        salt = $urandom;
        submit(4'b1111, base_addr());
        n = 0;
        while (!(issued_cnt == 16 && rsp_cnt == 7) && n < 300) begin @(negedge clk); n++; end
        chk("abort_reached_wait", 512'(issued_cnt == 16 && rsp_cnt == 7), 512'(1));
        @(negedge clk);
        chk("abort_in_wait", 512'(bus.mem_rsp_ready && !bus.mem_req_valid && !bus.out_valid), 512'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_req_ready", 512'(bus.req_ready), 512'(0));
        chk("abort_mem_req_valid", 512'(bus.mem_req_valid), 512'(0));
        chk("abort_mem_rsp_ready", 512'(bus.mem_rsp_ready), 512'(0));
        chk("abort_out_valid", 512'(bus.out_valid), 512'(0));
        chk("abort_out_data", 512'(bus.out_data), 512'(0));
        pend_q.delete();
        mode = M_ONE;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_req_ready_release", 512'(bus.req_ready), 512'(1));
        @(negedge clk);
        salt = $urandom;
        submit(4'b1111, rand_addr());
        finish_req(0, 16, 18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
